// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin two-port sequencer for the 8x16 data memory
module data_mem_arbiter #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 16,
  parameter int INIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              mem_rst,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(INIT_CYCLES + 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    init_cnt, init_cnt_n;
  logic                prio, prio_n;
  logic                win, win_n;
  logic                we_l, we_n;
  logic [ADDR_W-1:0]   addr_l, addr_n;
  logic [DATA_W-1:0]   wdata_l, wdata_n;

  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    prio_n     = prio;
    win_n      = win;
    we_n       = we_l;
    addr_n     = addr_l;
    wdata_n    = wdata_l;
    case (state)
      S_INIT: begin
        if (init_cnt == CNT_W'(INIT_CYCLES)) state_n = S_IDLE;
        else                                 init_cnt_n = init_cnt + 1'b1;
      end
      S_IDLE: begin
        if (req0 | req1) begin
          // a lone requester always wins; a tie goes to the port named by prio
          win_n   = (req0 & req1) ? prio : req1;
          we_n    = win_n ? we1 : we0;
          addr_n  = win_n ? addr1 : addr0;
          wdata_n = win_n ? wdata1 : wdata0;
          prio_n  = ~win_n;
          state_n = S_ACCESS;
        end
      end
      S_ACCESS: state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_INIT;
    endcase
  end

  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      prio      <= 1'b0;
      win       <= 1'b0;
      we_l      <= 1'b0;
      addr_l    <= '0;
      wdata_l   <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      busy      <= 1'b1;
      mem_rst   <= 1'b1;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      init_cnt  <= init_cnt_n;
      prio      <= prio_n;
      win       <= win_n;
      we_l      <= we_n;
      addr_l    <= addr_n;
      wdata_l   <= wdata_n;
      busy      <= (state_n != S_IDLE);
      mem_rst   <= (state_n == S_INIT);
      mem_write <= (state_n == S_ACCESS) & we_n;
      mem_read  <= (state_n == S_ACCESS) & ~we_n;
      ack0      <= (state_n == S_DONE) & ~win_n;
      ack1      <= (state_n == S_DONE) & win_n;
      if (state_n == S_ACCESS) begin
        mem_addr  <= addr_n;
        mem_wdata <= wdata_n;
      end
      if (state == S_ACCESS && mem_read) begin
        if (win) rdata1 <= mem_rdata;
        else     rdata0 <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed bench for data_mem_arbiter with a behavioural 8x16 memory
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [2:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, busy, mem_rst, mem_write, mem_read;
  logic [15:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [2:0]  mem_addr;

  int n_cmp = 0;
  int n_err = 0;
  int viol = 0;
  int ack0_cnt = 0;
  int wr_cnt = 0;
  logic [2:0] wr_addr = '0;
  logic prev0 = 1'b0, prev1 = 1'b0;

  logic [15:0] mem [8];

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(3), .DATA_W(16), .INIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .mem_rst(mem_rst), .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // init image: 0->0045, 1->0006, 2->0009, 4->0000
  always @(posedge clk) begin
    if (mem_rst === 1'b1) begin
      mem[0] <= 16'h0045; mem[1] <= 16'h0006; mem[2] <= 16'h0009; mem[3] <= 16'h1111;
      mem[4] <= 16'h0000; mem[5] <= 16'h2222; mem[6] <= 16'h3333; mem[7] <= 16'h4444;
    end else if (mem_write === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_read === 1'b1) ? mem[mem_addr] : 16'hxxxx;

  always @(negedge clk) begin
    if (mem_write === 1'b1 && mem_read === 1'b1) viol++;
    if (ack0 === 1'b1 && ack1 === 1'b1) viol++;
    if ((ack0 === 1'b1 && prev0) || (ack1 === 1'b1 && prev1)) viol++;
    prev0 = (ack0 === 1'b1);
    prev1 = (ack1 === 1'b1);
    if (ack0 === 1'b1) ack0_cnt++;
    if (mem_write === 1'b1) begin
      wr_cnt++;
      wr_addr = mem_addr;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_access(input int p, input logic w, input logic [2:0] a,
                           input logic [15:0] d, output int lat);
    if (p == 0) begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!((p == 0) ? (ack0 === 1'b1) : (ack1 === 1'b1)) && lat < 20);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  initial begin
    int lat, n, t, wr_before, ack_before;
    logic [3:0] seq;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // 1: reset, init pulse, first read
    tick(); tick();
    check("rst_mem_rst", mem_rst, 1);
    check("rst_busy", busy, 1);
    check("rst_acks", {ack0, ack1}, 0);
    check("rst_rdata", {rdata0, rdata1}, 0);
    check("rst_strobes", {mem_write, mem_read, mem_addr}, 0);
    rst = 1'b1;
    tick();
    check("init_c1_mem_rst", mem_rst, 1);
    tick();
    check("init_c2_mem_rst", mem_rst, 1);
    tick();
    check("init_end_mem_rst", mem_rst, 0);
    check("init_end_busy", busy, 0);
    do_access(0, 1'b0, 3'd0, 16'h0, lat);
    check("t1_latency", lat, 2);
    check("t1_rdata0", rdata0, 16'h0045);

    // 2: port1 write then read back
    wr_before = wr_cnt;
    do_access(1, 1'b1, 3'd5, 16'hBEEF, lat);
    check("t2_wr_latency", lat, 2);
    check("t2_wr_pulses", wr_cnt - wr_before, 1);
    check("t2_wr_addr", wr_addr, 3'd5);
    do_access(1, 1'b0, 3'd5, 16'h0, lat);
    check("t2_rdata1", rdata1, 16'hBEEF);

    // 3: both held, alternating grants
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd2;
    n = 0; t = 0; seq = '0;
    while (n < 4 && t < 40) begin
      tick();
      t++;
      if (ack0 === 1'b1) begin seq = {seq[2:0], 1'b0}; n++; end
      if (ack1 === 1'b1) begin seq = {seq[2:0], 1'b1}; n++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check("t3_ack_count", n, 4);
    check("t3_ack_order", seq, 4'b0101);
    check("t3_cycles", t, 11);
    check("t3_rdata0", rdata0, 16'h0006);
    check("t3_rdata1", rdata1, 16'h0009);

    // 4: req1 arrives during port0's write access
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd3; wdata0 = 16'hA5A5;
    tick();
    check("t4_strobe", {mem_write, mem_read, mem_addr}, {1'b1, 1'b0, 3'd3});
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd3;
    tick();
    check("t4_ack0", {ack0, ack1}, 2'b10);
    req0 = 1'b0;
    t = 0;
    do begin
      tick();
      t++;
    end while (ack1 !== 1'b1 && t < 20);
    req1 = 1'b0;
    check("t4_ack1_after", t, 3);
    check("t4_rdata1", rdata1, 16'hA5A5);
    tick();
    check("t4_ack1_pulse", ack1, 0);

    // 5: reset during a write access
    ack_before = ack0_cnt;
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd4; wdata0 = 16'h7777;
    tick();
    check("t5_in_access", mem_write, 1);
    rst = 1'b0; req0 = 1'b0;
    tick();
    check("t5_abort", {ack0, mem_write, mem_rst, rdata0}, {1'b0, 1'b0, 1'b1, 16'h0});
    tick();
    rst = 1'b1;
    tick(); tick(); tick();
    check("t5_reinit_busy", busy, 0);
    check("t5_no_ack0", ack0_cnt - ack_before, 0);
    do_access(0, 1'b0, 3'd4, 16'h0, lat);
    check("t5_rdata0", rdata0, 16'h0000);

    // 6: per-port read data is independent
    do_access(0, 1'b0, 3'd2, 16'h0, lat);
    check("t6_rdata0", rdata0, 16'h0009);
    do_access(1, 1'b0, 3'd0, 16'h0, lat);
    check("t6_rdata1", rdata1, 16'h0045);
    check("t6_rdata0_held", rdata0, 16'h0009);

    check("protocol_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
